issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Register-hazard scoreboard and issue gate between the decode stage and execute.
- Holds a per-register count of in-flight writes.
- Stalls a decoded instruction while any source register it reads, or its destination, is blocked.
- Releases registers on writeback, and clears all state on pipeline flush.

Parameters:
REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero.
IDX_WIDTH, 5, register index width; must equal clog2(REG_COUNT).
CNT_WIDTH, 2, width of each per-register pending-write counter; maximum in-flight writes per register is 2^CNT_WIDTH-1.
STALL_CNT_WIDTH, 16, width of the saturating stall-cycle performance counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
dec_valid  input  1  decoded instruction present
dec_ready  output  1  scoreboard accepts the decoded instruction this cycle
dec_rs1  input  IDX_WIDTH  source register 1 (0 when unused)
dec_rs2  input  IDX_WIDTH  source register 2 (0 when unused)
dec_rd  input  IDX_WIDTH  destination register (0 when none)
iss_valid  output  1  instruction issued to execute
iss_ready  input  1  execute accepts the instruction
wb_valid  input  1  a register write retires this cycle
wb_rd  input  IDX_WIDTH  register written at retirement
flush  input  1  pipeline flush; discard all pending state
busy_mask  output  REG_COUNT  bit i set while the count for register i is nonzero
stall_cycles  output  STALL_CNT_WIDTH  saturating count of hazard-stall cycles

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state is updated on the rising edge of clk only.
- Reset:
  - all counters = 0; stall_cycles = 0; busy_mask = 0.
  - While rst is high, dec_ready = 0 and iss_valid = 0.
- State: cnt[i], CNT_WIDTH bits each, for i = 1..REG_COUNT-1. cnt[0] does not exist and reads as 0.
- Hazard (combinational, from registered counts only; no same-cycle writeback bypass):
  - hazard = (rs1 != 0 and cnt[rs1] != 0) or (rs2 != 0 and cnt[rs2] != 0) or (rd != 0 and cnt[rd] == max).
  - A writeback in cycle N unblocks a dependent instruction in cycle N+1, not in cycle N.
- Handshake (combinational pass-through, zero latency):
  - iss_valid = dec_valid and not hazard and not flush and not rst.
  - dec_ready = iss_ready and not hazard and not flush and not rst.
  - fire = dec_valid and dec_ready.
  - dec_ready does not depend on dec_valid.
  - Register indices are ignored when dec_valid = 0.
- Counter update, evaluated in priority order:
  1. rst: all counters cleared.
  2. flush: all counters cleared. Fire and wb in the same cycle are ignored.
  3. Otherwise:
     - inc = fire and dec_rd != 0; dec = wb_valid and wb_rd != 0 and cnt[wb_rd] != 0.
     - Same register, both inc and dec: count unchanged.
     - Different registers: both applied.
     - Writeback to a register with count 0 (a write retired after a flush) is silently ignored; no underflow.
     - Increment never overflows, because hazard blocks the fire at max.
- busy_mask: registered view of the counters. Bit i = (cnt[i] != 0); bit 0 is always 0. It reflects the counter state after the most recent edge.
- stall_cycles:
  - Increments on each edge where dec_valid = 1, hazard = 1 and flush = 0.
  - Does not count cycles where iss_ready = 0 and there is no hazard.
  - Saturates at all-ones. Cleared only by rst.
- rs1 = rs2 = rd (for example, add x5,x5,x5 with x5 idle): no hazard. The instruction fires and cnt[5] goes to 1.
- Reset mid-operation clears everything regardless of in-flight writebacks. Later wb_valid pulses to zero counts are ignored.

Test Plan:
- Reset: hold rst 2 cycles with dec_valid = 1 -> dec_ready = 0, iss_valid = 0, busy_mask = 0, stall_cycles = 0.
- RAW stall:
  - Stimulus: issue rd = 5 (fire), then rs1 = 5 with iss_ready = 1 for 3 cycles, then wb_valid with wb_rd = 5.
  - Required: busy_mask = 0x20; dec_ready = 0 for those 3 cycles plus the wb cycle; stall_cycles = 4.
  - Required: the instruction fires the cycle after wb, and busy_mask = 0 after that edge.
- WAW saturation:
  - Stimulus: issue rd = 7 three times, then a fourth time.
  - Required: fourth is blocked (cnt = 3); one wb to 7 lets it fire next cycle, leaving cnt = 3.
- Simultaneous inc/dec: fire rd = 9 in the same cycle as wb_rd = 9 with cnt[9] = 1 -> cnt[9] stays 1 and busy_mask bit 9 stays set.
- Flush:
  - Stimulus: registers 3, 4, 10 pending; flush together with dec_valid = 1 and wb_rd = 3.
  - Required: dec_ready = 0 and iss_valid = 0 that cycle; busy_mask = 0 next cycle.
  - Required: a subsequent wb_rd = 4 is ignored with no underflow (busy_mask remains 0).
- x0 and backpressure:
  - Required: rd = 0 never sets busy_mask; rs1 = 0 never stalls.
  - Required: with no hazard and iss_ready = 0, dec_ready = 0, iss_valid = 1, and stall_cycles is unchanged.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard between decode and execute: tracks in-flight writes
// per architectural register and holds back instructions that touch a busy register.
module issue_scoreboard #(
  parameter int REG_COUNT       = 32,
  parameter int IDX_WIDTH       = 5,
  parameter int CNT_WIDTH       = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_valid,
  output logic                       dec_ready,
  input  logic [IDX_WIDTH-1:0]       dec_rs1,
  input  logic [IDX_WIDTH-1:0]       dec_rs2,
  input  logic [IDX_WIDTH-1:0]       dec_rd,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  input  logic                       wb_valid,
  input  logic [IDX_WIDTH-1:0]       wb_rd,
  input  logic                       flush,
  output logic [REG_COUNT-1:0]       busy_mask,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]       cnt [REG_COUNT];
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  logic rs1_hit, rs2_hit, rd_full, hazard;
  logic fire, inc, dec;
  logic [REG_COUNT-1:0] inc_sel, dec_sel;

  function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(
    input logic [STALL_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + STALL_CNT_WIDTH'(1);
  endfunction

  // Hazard sees only registered counts, so a writeback unblocks one cycle later.
  assign rs1_hit = (dec_rs1 != '0) && (cnt[dec_rs1] != '0);
  assign rs2_hit = (dec_rs2 != '0) && (cnt[dec_rs2] != '0);
  assign rd_full = (dec_rd  != '0) && (cnt[dec_rd] == CNT_MAX);
  assign hazard  = rs1_hit || rs2_hit || rd_full;

  assign iss_valid = dec_valid && !hazard && !flush && !rst;
  assign dec_ready = iss_ready && !hazard && !flush && !rst;
  assign fire      = dec_valid && dec_ready;

  assign inc     = fire && (dec_rd != '0);
  assign dec     = wb_valid && (wb_rd != '0) && (cnt[wb_rd] != '0);
  assign inc_sel = inc ? (REG_COUNT'(1) << dec_rd) : '0;
  assign dec_sel = dec ? (REG_COUNT'(1) << wb_rd)  : '0;

  // An issue and a retirement to the same register cancel out.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < REG_COUNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (i == 0)
          cnt[i] <= '0;
        else if (inc_sel[i] && !dec_sel[i])
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        else if (dec_sel[i] && !inc_sel[i])
          cnt[i] <= cnt[i] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (dec_valid && hazard && !flush)
      stall_q <= sat_inc(stall_q);
  end

  assign stall_cycles = stall_q;

  assign busy_mask[0] = 1'b0;
  for (genvar g = 1; g < REG_COUNT; g++) begin : g_busy
    assign busy_mask[g] = (cnt[g] != '0);
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard: hazards, saturation,
// simultaneous issue/retire, flush, x0 handling and backpressure.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        iss_valid;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_mask;
  logic [15:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  issue_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .busy_mask    (busy_mask),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rdy);
    dec_valid = v;
    dec_rs1   = rs1;
    dec_rs2   = rs2;
    dec_rd    = rd;
    iss_ready = rdy;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    wb_valid = v;
    wb_rd    = rd;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drv(1'b1, 5'd0, 5'd0, 5'd1, 1'b1);
    wb(1'b0, 5'd0);

    // Reset held two cycles with a valid instruction present
    tick();
    chk("rst_ready", dec_ready, 0);
    chk("rst_valid", iss_valid, 0);
    tick();
    chk("rst_ready2", dec_ready, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", stall_cycles, 0);
    rst = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;

    // RAW: issue rd=5, then consumer of x5 stalls until one cycle after wb
    drv(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    chk("raw_prod_ready", dec_ready, 1);
    chk("raw_prod_valid", iss_valid, 1);
    tick();
    chk("raw_busy", busy_mask, 32'h20);
    drv(1'b1, 5'd5, 5'd0, 5'd0, 1'b1);
    #1;
    chk("raw_stall_ready", dec_ready, 0);
    chk("raw_stall_valid", iss_valid, 0);
    tick(); tick(); tick();
    chk("raw_stall3", stall_cycles, 3);
    wb(1'b1, 5'd5);
    #1;
    chk("raw_wb_nobypass", dec_ready, 0);
    tick();
    wb(1'b0, 5'd0);
    chk("raw_stall4", stall_cycles, 4);
    chk("raw_busy_clr", busy_mask, 0);
    chk("raw_after_wb_ready", dec_ready, 1);
    chk("raw_after_wb_valid", iss_valid, 1);
    tick();
    chk("raw_fire_busy", busy_mask, 0);
    chk("raw_fire_stall", stall_cycles, 4);

    // WAW saturation on x7
    drv(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("waw_ready", dec_ready, 1);
      tick();
    end
    chk("waw_busy", busy_mask, 32'h80);
    chk("waw_full_blocked", dec_ready, 0);
    wb(1'b1, 5'd7);
    #1;
    chk("waw_full_wb_cycle", iss_valid, 0);
    tick();
    wb(1'b0, 5'd0);
    chk("waw_stall", stall_cycles, 5);
    chk("waw_fire_after_wb", dec_ready, 1);
    tick();
    drv(1'b0, 5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    chk("waw_refull_ready", dec_ready, 0);
    tick();
    chk("waw_invalid_nostall", stall_cycles, 5);
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    wb(1'b1, 5'd7);
    tick(); tick();
    chk("waw_drain2", busy_mask, 32'h80);
    tick();
    wb(1'b0, 5'd0);
    chk("waw_drain3", busy_mask, 0);

    // Simultaneous issue and retire on x9 keeps the count at 1
    drv(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    chk("sim_busy1", busy_mask, 32'h200);
    wb(1'b1, 5'd9);
    #1;
    chk("sim_ready", dec_ready, 1);
    tick();
    chk("sim_busy_kept", busy_mask, 32'h200);
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    wb(1'b0, 5'd0);
    chk("sim_single_wb_clears", busy_mask, 0);

    // Flush with x3, x4, x10 pending
    drv(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    dec_rd = 5'd4;
    tick();
    dec_rd = 5'd10;
    tick();
    chk("fl_busy", busy_mask, 32'h418);
    flush = 1'b1;
    dec_rd = 5'd11;
    wb(1'b1, 5'd3);
    #1;
    chk("fl_ready", dec_ready, 0);
    chk("fl_valid", iss_valid, 0);
    tick();
    flush = 1'b0;
    chk("fl_busy_clr", busy_mask, 0);
    chk("fl_stall", stall_cycles, 5);
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    wb(1'b1, 5'd4);
    tick();
    wb(1'b0, 5'd0);
    chk("fl_late_wb_busy", busy_mask, 0);
    drv(1'b1, 5'd4, 5'd0, 5'd0, 1'b1);
    #1;
    chk("fl_no_underflow", dec_ready, 1);
    tick();

    // x0 never busy, never stalls
    drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    chk("x0_rd_busy", busy_mask, 0);
    chk("x0_rs_ready", dec_ready, 1);
    dec_rd = 5'd12;
    tick();
    drv(1'b1, 5'd0, 5'd12, 5'd0, 1'b1);
    #1;
    chk("rs2_hazard", dec_ready, 0);
    tick();
    chk("rs2_stall", stall_cycles, 6);
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    wb(1'b1, 5'd12);
    tick();
    wb(1'b0, 5'd0);

    // Backpressure without hazard does not count as a stall
    drv(1'b1, 5'd0, 5'd0, 5'd13, 1'b0);
    #1;
    chk("bp_ready", dec_ready, 0);
    chk("bp_valid", iss_valid, 1);
    tick();
    chk("bp_nofire", busy_mask, 0);
    chk("bp_stall", stall_cycles, 6);

    // rs1 = rs2 = rd on an idle register issues
    drv(1'b1, 5'd5, 5'd5, 5'd5, 1'b1);
    #1;
    chk("same_ready", dec_ready, 1);
    tick();
    chk("same_busy", busy_mask, 32'h20);

    // Reset mid-operation, then a late writeback is ignored
    drv(1'b1, 5'd0, 5'd0, 5'd6, 1'b1);
    tick();
    chk("mid_busy", busy_mask, 32'h60);
    rst = 1'b1;
    wb(1'b1, 5'd6);
    tick();
    rst = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("mid_rst_busy", busy_mask, 0);
    chk("mid_rst_stall", stall_cycles, 0);
    tick();
    wb(1'b0, 5'd0);
    chk("mid_late_wb", busy_mask, 0);
    drv(1'b1, 5'd6, 5'd5, 5'd0, 1'b1);
    #1;
    chk("mid_no_underflow", dec_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
